// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control-bit indices and FSM states.
package pipe_pkg;

    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the EX->MEM register: a valid flag plus a flat payload.
// load wins over clear; clear drops only the valid flag so the payload keeps its last value.
module pipe_slot #(
    parameter int W = 19
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a main slot and a skid slot, flush, gated control and a stall counter.
// Handshake: a beat moves on a side only in a cycle where both valid and ready are high at posedge clk1.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_B,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_B,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state_o
);

    localparam int PW = 2 * DATA_W + CTRL_W;

    state_e            state_q, state_d;
    logic              in_ready_q;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              accept, emit;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_valid, skid_valid;
    logic [PW-1:0]     in_payload, main_din, main_data, skid_data;

    assign in_payload = {in_ctrl, in_alu_out, in_B};
    assign accept     = in_valid & in_ready_q;
    assign emit       = main_valid & out_ready;

    // State register, registered ready and stall counter.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !emit)      state_d = TWO;
                    else if (!accept && emit) state_d = EMPTY;
                end
                TWO:     if (emit) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Slot steering: in TWO the skid beat refills main as main drains.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: main_load = accept;
                ONE: begin
                    main_load  = accept & emit;
                    skid_load  = accept & ~emit;
                    main_clear = emit & ~accept;
                end
                TWO: begin
                    main_from_skid = 1'b1;
                    main_load      = emit & skid_valid;
                    skid_clear     = emit;
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + 1'b1;
    end

    assign main_din = main_from_skid ? skid_data : in_payload;

    pipe_slot #(.W(PW)) u_main (
        .clk_i   (clk1),
        .rst_i   (rst),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_din),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk_i   (clk1),
        .rst_i   (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_payload),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // Bubbles must never carry MemWrite/MemRead into MEM.
    assign out_valid   = main_valid;
    assign out_B       = main_data[DATA_W-1:0];
    assign out_alu_out = main_data[2*DATA_W-1:DATA_W];
    assign out_ctrl    = main_valid ? main_data[PW-1:2*DATA_W] : '0;
    assign in_ready    = in_ready_q;
    assign stall_cnt   = stall_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed vector table, hand-written corner sequences and a random run
// compared against a queue-based model of a two-deep FIFO stage.
module tb_ex_mem_pipe_reg;
    import pipe_pkg::*;

    localparam int DW = 16;
    localparam int CW = 3;
    localparam int NW = 4;
    localparam int PW = 2 * DW + CW;
    localparam int SAT = (1 << NW) - 1;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_B = '0;
    logic [DW-1:0] in_alu_out = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_B;
    logic [DW-1:0] out_alu_out;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    ex_mem_pipe_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk1        (clk1),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_B        (in_B),
        .in_alu_out  (in_alu_out),
        .in_ctrl     (in_ctrl),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_B       (out_B),
        .out_alu_out (out_alu_out),
        .out_ctrl    (out_ctrl),
        .stall_cnt   (stall_cnt),
        .dbg_state_o (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] b, input logic [DW-1:0] alu,
                         input logic [CW-1:0] c, input logic r, input logic f);
        in_valid   = v;
        in_B       = b;
        in_alu_out = alu;
        in_ctrl    = c;
        out_ready  = r;
        flush      = f;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk1);
        rst = 1'b0;
    endtask

    // Bubbles must never present nonzero control, whatever test is running.
    always @(negedge clk1) begin
        if (!rst && !out_valid) chk("bubble_ctrl", 32'(out_ctrl), 32'd0);
    end

    typedef struct {
        logic          v;
        logic [DW-1:0] b;
        logic [DW-1:0] alu;
        logic [CW-1:0] c;
        logic          r;
        logic          f;
        logic          e_valid;
        logic [DW-1:0] e_b;
        logic [DW-1:0] e_alu;
        logic [CW-1:0] e_ctrl;
        logic          e_ready;
        logic [NW-1:0] e_stall;
        logic [1:0]    e_state;
    } vec_t;

    vec_t tbl[14];

    logic [PW-1:0] exp_q[$];

    initial begin
        logic [PW-1:0] last_beat, beat, front;
        logic          exp_rdy, v, r, f;
        int            exp_cnt, sent, cyc;

        // Stream 0x10..0x17 at full rate, then back-pressure with 0xA1/0xA2.
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 16'hB000 + 16'(k), 16'h0010 + 16'(k), 3'b100, 1'b1, 1'b0,
                       1'b1, 16'hB000 + 16'(k), 16'h0010 + 16'(k), 3'b100, 1'b1, 4'd0, 2'(ONE)};
        tbl[8]  = '{1'b0, 16'h0, 16'h0, 3'b000, 1'b1, 1'b0,
                    1'b0, 16'hB007, 16'h0017, 3'b000, 1'b1, 4'd0, 2'(EMPTY)};
        tbl[9]  = '{1'b1, 16'hB0A1, 16'h00A1, 3'b010, 1'b0, 1'b0,
                    1'b1, 16'hB0A1, 16'h00A1, 3'b010, 1'b1, 4'd0, 2'(ONE)};
        tbl[10] = '{1'b1, 16'hB0A2, 16'h00A2, 3'b010, 1'b0, 1'b0,
                    1'b1, 16'hB0A1, 16'h00A1, 3'b010, 1'b0, 4'd1, 2'(TWO)};
        tbl[11] = '{1'b0, 16'h0, 16'h0, 3'b000, 1'b0, 1'b0,
                    1'b1, 16'hB0A1, 16'h00A1, 3'b010, 1'b0, 4'd2, 2'(TWO)};
        tbl[12] = '{1'b0, 16'h0, 16'h0, 3'b000, 1'b1, 1'b0,
                    1'b1, 16'hB0A2, 16'h00A2, 3'b010, 1'b1, 4'd2, 2'(ONE)};
        tbl[13] = '{1'b0, 16'h0, 16'h0, 3'b000, 1'b1, 1'b0,
                    1'b0, 16'hB0A2, 16'h00A2, 3'b000, 1'b1, 4'd2, 2'(EMPTY)};

        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_b", 32'(out_B), 32'd0);
        chk("rst_alu", 32'(out_alu_out), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(EMPTY));

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].b, tbl[i].alu, tbl[i].c, tbl[i].r, tbl[i].f);
            @(negedge clk1);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_b", i), 32'(out_B), 32'(tbl[i].e_b));
            chk($sformatf("vec%0d_alu", i), 32'(out_alu_out), 32'(tbl[i].e_alu));
            chk($sformatf("vec%0d_ctrl", i), 32'(out_ctrl), 32'(tbl[i].e_ctrl));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].e_stall));
            chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(tbl[i].e_state));
        end

        // Flush while full with a store arriving: everything dropped, no store escapes.
        drive(1'b1, 16'hB031, 16'h0031, 3'b001, 1'b0, 1'b0);
        @(negedge clk1);
        drive(1'b1, 16'hB032, 16'h0032, 3'b001, 1'b0, 1'b0);
        @(negedge clk1);
        chk("fl_pre_state", 32'(dbg_state), 32'(TWO));
        chk("fl_pre_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 16'hB033, 16'h0033, 3'b001, 1'b0, 1'b1);
        @(negedge clk1);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ctrl", 32'(out_ctrl), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        chk("fl_state", 32'(dbg_state), 32'(EMPTY));
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        @(negedge clk1);
        chk("fl_post_valid", 32'(out_valid), 32'd0);
        chk("fl_post_hold", 32'(out_alu_out), 32'h31);

        // Stall counter saturation; flush leaves it, reset clears it.
        do_reset();
        drive(1'b1, 16'hB044, 16'h0044, 3'b110, 1'b0, 1'b0);
        @(negedge clk1);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        repeat (20) @(negedge clk1);
        chk("sat_20", 32'(stall_cnt), 32'(SAT));
        @(negedge clk1);
        chk("sat_21", 32'(stall_cnt), 32'(SAT));
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
        @(negedge clk1);
        chk("sat_flush", 32'(stall_cnt), 32'(SAT));
        chk("sat_flush_valid", 32'(out_valid), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk1);
        chk("sat_idle", 32'(stall_cnt), 32'(SAT));
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        chk("sat_rst", 32'(stall_cnt), 32'd0);

        // Reset while holding two beats.
        drive(1'b1, 16'hB061, 16'h0061, 3'b011, 1'b0, 1'b0);
        @(negedge clk1);
        drive(1'b1, 16'hB062, 16'h0062, 3'b011, 1'b0, 1'b0);
        @(negedge clk1);
        chk("mr_pre_state", 32'(dbg_state), 32'(TWO));
        drive(1'b1, 16'hB063, 16'h0063, 3'b011, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_b", 32'(out_B), 32'd0);
        chk("mr_alu", 32'(out_alu_out), 32'd0);
        chk("mr_ctrl", 32'(out_ctrl), 32'd0);
        chk("mr_stall", 32'(stall_cnt), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        drive(1'b1, 16'hB055, 16'h0055, 3'b011, 1'b1, 1'b0);
        @(negedge clk1);
        chk("mr_55_valid", 32'(out_valid), 32'd1);
        chk("mr_55_alu", 32'(out_alu_out), 32'h55);
        chk("mr_55_b", 32'(out_B), 32'hB055);
        drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
        @(negedge clk1);
        chk("mr_alone", 32'(out_valid), 32'd0);
        chk("mr_alone_hold", 32'(out_alu_out), 32'h55);

        // Random traffic against a two-deep FIFO model.
        do_reset();
        exp_q.delete();
        last_beat = '0;
        exp_rdy   = 1'b1;
        exp_cnt   = 0;
        sent      = 0;
        cyc       = 0;
        while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            front = (exp_q.size() != 0) ? exp_q[0] : last_beat;
            chk("r_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("r_b", 32'(out_B), 32'(front[DW-1:0]));
            chk("r_alu", 32'(out_alu_out), 32'(front[2*DW-1:DW]));
            chk("r_ctrl", 32'(out_ctrl), (exp_q.size() != 0) ? 32'(front[PW-1:2*DW]) : 32'd0);
            chk("r_ready", 32'(in_ready), 32'(exp_rdy));
            chk("r_stall", 32'(stall_cnt), 32'(exp_cnt));

            v    = (sent < 1000) && ($urandom_range(0, 3) != 0);
            r    = ($urandom_range(0, 2) != 0);
            f    = (sent < 1000) && ($urandom_range(0, 63) == 0);
            beat = {3'($urandom), 16'($urandom), 16'($urandom)};
            drive(v, beat[DW-1:0], beat[2*DW-1:DW], beat[PW-1:2*DW], r, f);

            if (exp_q.size() != 0 && !r && exp_cnt < SAT) exp_cnt++;
            if (exp_q.size() != 0) last_beat = exp_q[0];
            if (f) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
                if (v && exp_rdy) begin
                    exp_q.push_back(beat);
                    sent++;
                end
            end
            exp_rdy = (exp_q.size() < 2);
            @(negedge clk1);
            cyc++;
        end
        chk("r_budget", 32'(cyc < 20000), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
